// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory controller.
// Contents: access-size encodings, controller FSM state type, wait-counter width.
package dmem_pkg;

  // Access sizes carried on req_size; 2'b11 is illegal.
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  // Wait counter covers WAIT_CYC in 0..15.
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/dmem_lane_fmt.sv
// Byte-lane formatting for the data-memory controller (purely combinational).
// Ports:
//   size, lane, is_unsigned : access size, byte lane (addr[1:0]), load extension mode
//   wdata                   : right-aligned store data
//   rword                   : word read from the array
//   be_c                    : byte enables for the store merge
//   wdata_rep_c             : store data replicated across lanes
//   rdata_ext_c             : extracted and sign/zero-extended load data
module dmem_lane_fmt
  import dmem_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  lane,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be_c,
  output logic [31:0] wdata_rep_c,
  output logic [31:0] rdata_ext_c
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane select: half uses only lane[1]; odd half lanes are rejected upstream.
  always_comb begin
    byte_sel = 8'(rword >> {lane, 3'b000});
    half_sel = lane[1] ? rword[31:16] : rword[15:0];
  end

  always_comb begin
    be_c        = 4'b0000;
    wdata_rep_c = wdata;
    rdata_ext_c = '0;
    case (size)
      SZ_B: begin
        be_c        = 4'b0001 << lane;
        wdata_rep_c = {4{wdata[7:0]}};
        rdata_ext_c = is_unsigned ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      end
      SZ_H: begin
        be_c        = lane[1] ? 4'b1100 : 4'b0011;
        wdata_rep_c = {2{wdata[15:0]}};
        rdata_ext_c = is_unsigned ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
      end
      SZ_W: begin
        be_c        = 4'b1111;
        rdata_ext_c = rword;
      end
      default: begin
        be_c = 4'b0000;
      end
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller for the MEM stage: byte/half/word loads and stores,
// valid/ready request, configurable wait states, one-cycle response pulse.
// Ports:
//   clk, rst         : clock, synchronous active-high reset
//   req_valid/ready  : request handshake (ready only in IDLE)
//   req_write        : 1=store, 0=load
//   req_size         : 00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned     : zero-extend loads when set
//   req_addr         : byte address
//   req_wdata        : right-aligned store data
//   rsp_valid        : one-cycle response pulse
//   rsp_rdata        : extended load data (0 for stores and errors)
//   rsp_err          : misaligned / out-of-range / illegal-size access
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned DEPTH    = 256,
  parameter int unsigned WAIT_CYC = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int unsigned     IDX_W    = $clog2(DEPTH);
  localparam logic [ADDR_W:0] ADDR_LIM = (ADDR_W + 1)'(DEPTH * 4);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((WAIT_CYC == 0) ? 0 : WAIT_CYC - 1);

  logic [DATA_W-1:0] mem_q [DEPTH];

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              req_ready_q, req_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0] pend_rdata_q, pend_rdata_d;
  logic              pend_err_q, pend_err_d;

  logic              accept_c;
  logic              err_c;
  logic              mem_we_c;
  logic [IDX_W-1:0]  idx_c;
  logic [DATA_W-1:0] rword_c;
  logic [DATA_W-1:0] merged_c;
  logic [3:0]        be_c;
  logic [31:0]       wdata_rep_c;
  logic [31:0]       rdata_ext_c;

  assign accept_c = req_valid & req_ready_q;
  assign idx_c    = req_addr[IDX_W+1:2];
  assign rword_c  = mem_q[idx_c];

  // Access legality, judged on the request as presented at acceptance.
  assign err_c = ({1'b0, req_addr} >= ADDR_LIM)
               | (req_size == 2'b11)
               | ((req_size == SZ_H) & req_addr[0])
               | ((req_size == SZ_W) & (req_addr[1:0] != 2'b00));

  dmem_lane_fmt u_lane_fmt (
    .size        (req_size),
    .lane        (req_addr[1:0]),
    .is_unsigned (req_unsigned),
    .wdata       (req_wdata),
    .rword       (rword_c),
    .be_c        (be_c),
    .wdata_rep_c (wdata_rep_c),
    .rdata_ext_c (rdata_ext_c)
  );

  // Read-modify-write merge: untouched bytes keep the stored value.
  always_comb begin
    merged_c = rword_c;
    for (int i = 0; i < 4; i++) begin
      if (be_c[i]) merged_c[8*i +: 8] = wdata_rep_c[8*i +: 8];
    end
  end

  // A request coinciding with reset is dropped, so it must not write either.
  assign mem_we_c = accept_c & req_write & ~err_c & ~rst;

  // Array is deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we_c) mem_q[idx_c] <= merged_c;
  end

  // Next state, response latch and handshake outputs.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pend_rdata_d = pend_rdata_q;
    pend_err_d   = pend_err_q;
    case (state_q)
      IDLE: begin
        if (accept_c) begin
          pend_err_d   = err_c;
          pend_rdata_d = (req_write || err_c) ? '0 : rdata_ext_c;
          if (WAIT_CYC == 0) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) state_d = RESP;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    req_ready_d = (state_d == IDLE);
    rsp_valid_d = (state_d == RESP);
    // Response data only changes when entering RESP; it holds otherwise.
    rsp_rdata_d = rsp_valid_d ? pend_rdata_d : rsp_rdata_q;
    rsp_err_d   = rsp_valid_d ? pend_err_d   : rsp_err_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      req_ready_q  <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      rsp_err_q    <= 1'b0;
      pend_rdata_q <= '0;
      pend_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      req_ready_q  <= req_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_err_q    <= rsp_err_d;
      pend_rdata_q <= pend_rdata_d;
      pend_err_q   <= pend_err_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: table-driven access vectors through a
// scoreboard on a WAIT_CYC=1 instance, plus throughput and reset sequences
// on WAIT_CYC=3 / WAIT_CYC=0 instances.
module tb_dmem_ctrl;
  import dmem_pkg::*;

  logic        clk;
  logic        rst;
  logic        req_valid, req_ready, req_write, req_unsigned;
  logic [1:0]  req_size;
  logic [15:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;

  logic        v3, rdy3, rv3, re3;
  logic [31:0] rd3;
  logic        v0, rdy0, rv0, re0;
  logic [31:0] rd0;
  logic        t_write, t_uns;
  logic [1:0]  t_size;
  logic [15:0] t_addr;
  logic [31:0] t_wdata;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  typedef struct {
    logic        w;
    logic [1:0]  sz;
    logic        u;
    logic [15:0] a;
    logic [31:0] wd;
    logic [31:0] er;
    logic        ee;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
    int          idx;
  } exp_t;

  vec_t        vecs[$];
  exp_t        sb[$];
  logic [31:0] exp_rdata;
  logic        exp_err;
  int          cur_idx;

  dmem_ctrl #(.DATA_W(32), .ADDR_W(16), .DEPTH(256), .WAIT_CYC(1)) u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  dmem_ctrl #(.DATA_W(32), .ADDR_W(16), .DEPTH(256), .WAIT_CYC(3)) u_w3 (
    .clk(clk), .rst(rst),
    .req_valid(v3), .req_ready(rdy3), .req_write(t_write),
    .req_size(t_size), .req_unsigned(t_uns), .req_addr(t_addr),
    .req_wdata(t_wdata),
    .rsp_valid(rv3), .rsp_rdata(rd3), .rsp_err(re3)
  );

  dmem_ctrl #(.DATA_W(32), .ADDR_W(16), .DEPTH(256), .WAIT_CYC(0)) u_w0 (
    .clk(clk), .rst(rst),
    .req_valid(v0), .req_ready(rdy0), .req_write(t_write),
    .req_size(t_size), .req_unsigned(t_uns), .req_addr(t_addr),
    .req_wdata(t_wdata),
    .rsp_valid(rv0), .rsp_rdata(rd0), .rsp_err(re0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic vec_t mk(input logic w, input logic [1:0] sz, input logic u,
                              input logic [15:0] a, input logic [31:0] wd,
                              input logic [31:0] er, input logic ee);
    vec_t v;
    v.w = w; v.sz = sz; v.u = u; v.a = a; v.wd = wd; v.er = er; v.ee = ee;
    return v;
  endfunction

  // Scoreboard: push at the negedge before an accepting edge, pop on rsp_valid.
  always @(negedge clk) begin
    if (rsp_valid) begin
      if (sb.size() == 0) begin
        check("spurious_rsp_valid", 32'(rsp_valid), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check($sformatf("v%0d_rdata", e.idx), rsp_rdata, e.rdata);
        check($sformatf("v%0d_err", e.idx), 32'(rsp_err), 32'(e.err));
        // rsp_valid rises WAIT_CYC edges after the accept edge (sampled one edge later).
        check($sformatf("v%0d_latency", e.idx), 32'(cyc - e.acc), 32'd1);
      end
    end
    if (req_valid && req_ready && !rst) begin
      exp_t n;
      n.rdata = exp_rdata; n.err = exp_err; n.acc = cyc + 1; n.idx = cur_idx;
      sb.push_back(n);
    end
  end

  task automatic do_req(input vec_t v, input int idx);
    bit ok;
    @(posedge clk); #1;
    req_write = v.w; req_size = v.sz; req_unsigned = v.u; req_addr = v.a;
    req_wdata = v.wd; exp_rdata = v.er; exp_err = v.ee; cur_idx = idx;
    req_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (req_ready) ok = 1'b1;
    end
    if (!ok) check($sformatf("v%0d_accept_timeout", idx), 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 30 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) check("drain_timeout", 32'(sb.size()), 32'd0);
  endtask

  // Hold req_valid high on one of the throughput instances and measure spacing.
  task automatic run_tp(input bit sel3, input int wc);
    int last, acc, rsps;
    logic vv, rdy, rv, re;
    logic [31:0] rd;
    string tg;
    tg = sel3 ? "w3" : "w0";
    last = -1; acc = 0; rsps = 0;
    @(posedge clk); #1;
    if (sel3) v3 = 1'b1; else v0 = 1'b1;
    for (int i = 0; i < 36; i++) begin
      @(negedge clk);
      vv  = sel3 ? v3 : v0;
      rdy = sel3 ? rdy3 : rdy0;
      rv  = sel3 ? rv3 : rv0;
      re  = sel3 ? re3 : re0;
      rd  = sel3 ? rd3 : rd0;
      if (rv) begin
        rsps++;
        check({tg, "_rsp_latency"}, 32'(cyc - last), 32'(wc + 1));
        check({tg, "_rsp_rdata"}, rd, 32'd0);
        check({tg, "_rsp_err"}, 32'(re), 32'd0);
      end
      if (vv && rdy) begin
        if (last >= 0) check({tg, "_accept_interval"}, 32'(cyc - last), 32'(wc + 2));
        last = cyc;
        acc++;
      end
      if (i == 25) begin
        @(posedge clk); #1;
        if (sel3) v3 = 1'b0; else v0 = 1'b0;
      end
    end
    check({tg, "_accept_count"}, 32'(acc), 32'(25 / (wc + 2) + 1));
    check({tg, "_one_rsp_per_accept"}, 32'(rsps), 32'(acc));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_size = SZ_W; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0; exp_rdata = '0; exp_err = 1'b0; cur_idx = -1;
    v3 = 1'b0; v0 = 1'b0;
    t_write = 1'b1; t_size = SZ_W; t_uns = 1'b0; t_addr = 16'h0020; t_wdata = 32'h0BADF00D;

    vecs.push_back(mk(1, SZ_W,  0, 16'h0010, 32'hDEADBEEF, 32'h0,        0));
    vecs.push_back(mk(0, SZ_W,  0, 16'h0010, 32'h0,        32'hDEADBEEF, 0));
    vecs.push_back(mk(1, SZ_B,  0, 16'h0011, 32'hFFFFFF7F, 32'h0,        0));
    vecs.push_back(mk(0, SZ_W,  1, 16'h0010, 32'h0,        32'hDEAD7FEF, 0));
    vecs.push_back(mk(0, SZ_B,  0, 16'h0013, 32'h0,        32'hFFFFFFDE, 0));
    vecs.push_back(mk(0, SZ_B,  1, 16'h0013, 32'h0,        32'h000000DE, 0));
    vecs.push_back(mk(0, SZ_H,  0, 16'h0012, 32'h0,        32'hFFFFDEAD, 0));
    vecs.push_back(mk(0, SZ_H,  0, 16'h0011, 32'h0,        32'h0,        1));
    vecs.push_back(mk(1, SZ_W,  0, 16'h0012, 32'h12345678, 32'h0,        1));
    vecs.push_back(mk(0, SZ_W,  0, 16'h0010, 32'h0,        32'hDEAD7FEF, 0));
    vecs.push_back(mk(1, SZ_W,  0, 16'h0000, 32'h55AA55AA, 32'h0,        0));
    vecs.push_back(mk(1, SZ_W,  0, 16'h0400, 32'h11111111, 32'h0,        1));
    vecs.push_back(mk(0, SZ_W,  0, 16'h0400, 32'h0,        32'h0,        1));
    vecs.push_back(mk(0, SZ_W,  0, 16'h0000, 32'h0,        32'h55AA55AA, 0));
    vecs.push_back(mk(1, 2'b11, 0, 16'h0010, 32'hFFFFFFFF, 32'h0,        1));
    vecs.push_back(mk(0, 2'b11, 0, 16'h0010, 32'h0,        32'h0,        1));
    vecs.push_back(mk(0, SZ_W,  0, 16'h0010, 32'h0,        32'hDEAD7FEF, 0));
    vecs.push_back(mk(1, SZ_W,  0, 16'h0014, 32'h01028304, 32'h0,        0));
    vecs.push_back(mk(1, SZ_H,  0, 16'h0016, 32'hABCD1234, 32'h0,        0));
    vecs.push_back(mk(0, SZ_W,  0, 16'h0014, 32'h0,        32'h12348304, 0));
    vecs.push_back(mk(0, SZ_H,  0, 16'h0014, 32'h0,        32'hFFFF8304, 0));
    vecs.push_back(mk(0, SZ_H,  1, 16'h0014, 32'h0,        32'h00008304, 0));
    vecs.push_back(mk(0, SZ_H,  0, 16'h0016, 32'h0,        32'h00001234, 0));
    vecs.push_back(mk(0, SZ_B,  0, 16'h0015, 32'h0,        32'hFFFFFF83, 0));
    vecs.push_back(mk(1, SZ_B,  0, 16'h03FF, 32'h000000CA, 32'h0,        0));
    vecs.push_back(mk(0, SZ_B,  1, 16'h03FF, 32'h0,        32'h000000CA, 0));
    vecs.push_back(mk(0, SZ_B,  0, 16'h03FF, 32'h0,        32'hFFFFFFCA, 0));
    vecs.push_back(mk(1, SZ_W,  0, 16'h0030, 32'hA5A5A5A5, 32'h0,        0));
    vecs.push_back(mk(0, SZ_W,  0, 16'h0030, 32'h0,        32'hA5A5A5A5, 0));

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_req_ready", 32'(req_ready), 32'd1);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_rsp_rdata", rsp_rdata, 32'd0);
    check("reset_rsp_err", 32'(rsp_err), 32'd0);
    check("reset_w3_ready", 32'(rdy3), 32'd1);
    check("reset_w0_ready", 32'(rdy0), 32'd1);

    foreach (vecs[i]) do_req(vecs[i], i);
    drain();

    // Reset while a load sits in WAIT: no response, ready right after reset.
    @(posedge clk); #1;
    req_write = 1'b0; req_size = SZ_W; req_unsigned = 1'b0; req_addr = 16'h0030;
    exp_rdata = 32'hA5A5A5A5; exp_err = 1'b0; cur_idx = 100; req_valid = 1'b1;
    @(negedge clk);
    check("rst_seq_ready_before", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    check("rst_seq_wait_no_rsp", 32'(rsp_valid), 32'd0);
    check("rst_seq_wait_not_ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_seq_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_seq_req_ready", 32'(req_ready), 32'd1);
    check("rst_seq_rsp_rdata", rsp_rdata, 32'd0);
    repeat (4) @(negedge clk);
    do_req(mk(0, SZ_W, 0, 16'h0030, 32'h0, 32'hA5A5A5A5, 0), 101);
    do_req(mk(0, SZ_W, 0, 16'h0010, 32'h0, 32'hDEAD7FEF, 0), 102);
    drain();

    run_tp(1'b1, 3);
    run_tp(1'b0, 0);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
Parametrised data-memory controller for the MEM stage of the pipelined CPU. It is the successor of the fixed 256x32 word-only data memory.
- Generalised in depth, data width and read latency.
- Adds byte/halfword/word accesses with byte-enable merge and load sign/zero extension.
- Adds misalignment and out-of-range error reporting.
- Uses a valid/ready request plus one-cycle response pulse, so the pipeline can stall on wait states.

Parameters:
- DATA_W, 32: data width in bits. Fixed at 32 for byte/half/word lanes; other values are illegal.
- ADDR_W, 16: byte address width.
- DEPTH, 256: number of DATA_W words. Must be a power of two, and DEPTH*4 <= 2^ADDR_W.
- WAIT_CYC, 1: extra wait cycles between acceptance and response, range 0..15.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request
- req_write  in  1  1=store, 0=load
- req_size  in  2  00=byte, 01=half, 10=word, 11=illegal
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0
- req_addr  in  ADDR_W  byte address
- req_wdata  in  DATA_W  store data, right-aligned
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  DATA_W  extended load data; 0 for stores and errors
- rsp_err  out  1  misaligned, out-of-range or illegal-size access; valid with rsp_valid

Behaviour:
- Reset (sync, rst=1 at edge):
  - state=IDLE, wait counter=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, req_ready=1 in the following cycle.
  - Memory array is not cleared.
  - A pending request is dropped with no response. A store already committed stays committed.
- FSM states: IDLE, WAIT, RESP.
  - req_ready = (state==IDLE).
  - Accept = req_valid & req_ready at the rising edge.
  - IDLE -> WAIT on accept if WAIT_CYC>0 (counter loaded with WAIT_CYC-1).
  - IDLE -> RESP on accept if WAIT_CYC==0.
  - WAIT: counter decrements each cycle; at counter==0 -> RESP.
  - RESP: rsp_valid=1 for exactly one cycle, then -> IDLE.
  - Latency: response is visible WAIT_CYC+1 cycles after the accept edge. Throughput is one access per WAIT_CYC+2 cycles.
- Error check, evaluated at accept and latched:
  - size==11, or
  - half with addr[0]=1, or
  - word with addr[1:0]!=0, or
  - addr >= DEPTH*4.
  - On error: no memory write, rsp_rdata=0, rsp_err=1.
- Word index = addr[log2(DEPTH)+1:2]; lane = addr[1:0].
- Store: commits at the accept edge as a read-modify-write merge.
  - Byte: req_wdata[7:0] written to lane addr[1:0].
  - Half: req_wdata[15:0] written to bytes {addr[1],0}..{addr[1],1}.
  - Word: full write.
  - Untouched bytes are preserved.
- Load: word read and latched at the accept edge.
  - Lane selected and extended per size/unsigned.
  - Word ignores req_unsigned.
  - A load after a store to the same address sees the new data, because the accesses are serialised.
- rsp_rdata/rsp_err hold their last value outside RESP; consumers qualify with rsp_valid.
- Inputs are ignored while req_ready=0.

Decomposition:
- Shared package dmem_pkg:
  - size encodings: SZ_B, SZ_H, SZ_W
  - FSM state enum: IDLE/WAIT/RESP
  - width of the wait counter
- One natural sub-module: dmem_lane_fmt, purely combinational. It provides:
  - byte-enable generation and store data replication;
  - load lane extraction plus sign/zero extension.
- The controller holds the array, the FSM and the error logic.

Test Plan:
- Reset then word store to 0x0010 of 0xDEADBEEF, then word load from 0x0010 (WAIT_CYC=1) -> rsp_valid 2 cycles after each accept; rsp_rdata=0xDEADBEEF, rsp_err=0.
- Byte store 0x7F to 0x0011, then loads from 0x0010 -> word load returns 0xDEAD7FEF. Byte load from 0x0013 signed returns 0xFFFFFFDE; unsigned returns 0x000000DE.
- Half load from 0x0012 signed -> 0xFFFFDEAD. Half load from 0x0011 -> rsp_err=1, rsp_rdata=0. A misaligned word store to 0x0012 leaves the word unchanged.
- Access to 0x0400 with DEPTH=256 -> rsp_err=1 and no write; size=11 -> rsp_err=1.
- Hold req_valid high with WAIT_CYC=3 and WAIT_CYC=0 -> req_ready low from the accept until after the RESP cycle. Exactly one rsp_valid per accept; accepts every 5 and every 2 cycles respectively.
- Assert rst during WAIT of a load -> no rsp_valid; req_ready=1 in the cycle after reset. A store accepted before the reset remains readable.
